cursor_overlay: RTL
===================

Name: cursor_overlay

Overview:
- Parametrised hardware-cursor compositor, successor to the fixed 16x16, 2-pixel-per-beat, set/clear cursor.
- Sits between the scan-out DMA and the pixel FIFO. Overlays a CUR_SIZE x CUR_SIZE, 2-bit-per-pixel cursor bitmap onto the pixel stream.
- Supports programmable colours, XOR-invert pixels, signed positions (partial off-screen clipping), a master enable and a fixed 2-cycle pipeline.

Parameters:
PIX_PER_BEAT, 2, pixels per stream beat; legal values 1, 2, 4.
CUR_SIZE, 32, cursor width and height in pixels; legal values 16, 32, 64.
PIX_W, 24, bits per pixel.

Ports:
clk  in  1  pixel/DMA clock
rstn  in  1  reset, asynchronous, active-low
frame_start  in  1  start-of-frame pulse; resets the raster position and latches the shadow registers
in_data  in  PIX_PER_BEAT*PIX_W  pixel beat; pixel 0 in the LSBs, leftmost on screen
in_valid  in  1  beat valid
out_data  out  PIX_PER_BEAT*PIX_W  composited beat
out_valid  out  1  composited beat valid
hact  in  16  active width; a multiple of PIX_PER_BEAT
cur_pos  in  32  [31:16] signed x, [15:0] signed y of the cursor top-left corner
cur_en  in  1  cursor enable
cur_col0  in  PIX_W  colour for code 01
cur_col1  in  PIX_W  colour for code 10
bm_addr  in  clog2(CUR_SIZE*CUR_SIZE/16)  bitmap word address
bm_wdata  in  32  bitmap write data
bm_we  in  1  bitmap write strobe
bm_wstrb  in  4  byte enables

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid=0, out_data=0.
  - Raster x and y = 0.
  - Shadow registers cur_pos, cur_en, cur_col0, cur_col1 = 0, so the cursor is off until the first frame_start.
  - Bitmap contents are not reset and are undefined.
- Bitmap layout:
  - Row-major, 16 pixels per 32-bit word.
  - Pixel k of a word occupies bits [31-2k:30-2k], so the leftmost pixel is in the MSBs.
  - Row r starts at word r*CUR_SIZE/16.
- Bitmap writes:
  - Applied on the clk edge when bm_we=1; only the byte lanes with bm_wstrb set are updated.
  - A write takes effect on the next beat entering stage 1. A same-cycle read sees the old data.
  - Writes are not shadowed.
- Pixel codes: 00 = pass through; 01 = cur_col0; 10 = cur_col1; 11 = input pixel XOR all-ones (invert).
- Raster tracking:
  - On each in_valid beat, x += PIX_PER_BEAT.
  - If x+PIX_PER_BEAT == hact, then x=0 and y += 1. y wraps at 2^16 with no error.
- frame_start:
  - Sets x=0, y=0 and copies cur_pos, cur_en and both colours into the shadow registers.
  - If frame_start and in_valid occur in the same cycle, that beat is pixel (0,0) of the new frame and is composited with the newly latched values.
- Hit test, per pixel i of the beat:
  - rx = x+i-cur_x and ry = y-cur_y, computed as 17-bit signed values.
  - The pixel is covered iff cur_en=1, 0<=rx<CUR_SIZE and 0<=ry<CUR_SIZE.
  - Negative cur_x/cur_y clip the cursor at the left/top edge. A cursor beyond hact is simply never hit.
- Pipeline, fixed 2-cycle latency with no backpressure:
  - Stage 1 registers the beat, the rx/ry values and the fetched bitmap codes.
  - Stage 2 registers out_data and out_valid.
  - out_valid(t+2) = in_valid(t). out_data holds its last value when out_valid=0.
- Non-beat cycles: frame_start without in_valid does not disturb beats already in the pipeline.
- Reset mid-line: all in-flight beats are dropped and out_valid deasserts immediately.

Optional Feature:
- Macro CURSOR_SCALE2_EN.
- When defined:
  - Adds input port cur_scale2 (1 bit), shadowed at frame_start.
  - When the shadowed value is 1, the covered area is 2*CUR_SIZE square, and each bitmap pixel covers 2x2 screen pixels, with code index (rx>>1, ry>>1).
- When undefined: the port is absent and the scale is always 1.

Test Plan:
1. Bitmap word 0 = 0x40000000 (pixel 0 code 01), cur_col0=0x123456, cur_pos=(10,5), cur_en=1, frame_start, hact=64, stream beats of 0x000000 -> only screen pixel (10,5) = 0x123456; out_valid exactly 2 cycles after each in_valid.
2. Code 11 at bitmap (0,0), input pixel 0xA5A5A5 at (10,5) -> output 0x5A5A5A; code 10 with cur_col1=0xFF0000 -> 0xFF0000.
3. cur_pos x=-3 (0xFFFD), y=0, all codes 01 -> screen columns 0..CUR_SIZE-4 of rows 0..CUR_SIZE-1 coloured; column CUR_SIZE-3 passes through.
4. Change cur_pos and cur_en=0 mid-frame -> the current frame is unchanged; after the next frame_start no pixel is modified.
5. bm_we with bm_wstrb=0100, wdata=0x00FF0000 over 0 -> only bits [23:16] set; a bm_we on the same cycle as the beat reading that word outputs old data.
6. frame_start coincident with in_valid at line end -> that beat is composited as (0,0); assert rstn low mid-line -> out_valid=0 immediately, no stale beats after release.

Source files
------------

// File: rtl/cursor_overlay.sv
// Hardware cursor compositor: overlays a CUR_SIZE^2 2bpp bitmap on a pixel stream, fixed 2-cycle latency.
// Optional feature `CURSOR_SCALE2_EN adds cur_scale2 (each bitmap pixel covers 2x2 screen pixels).
module cursor_overlay #(
  parameter int unsigned PIX_PER_BEAT = 2,
  parameter int unsigned CUR_SIZE     = 32,
  parameter int unsigned PIX_W        = 24
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     frame_start,
  input  logic [PIX_PER_BEAT*PIX_W-1:0]            in_data,
  input  logic                                     in_valid,
  output logic [PIX_PER_BEAT*PIX_W-1:0]            out_data,
  output logic                                     out_valid,
  input  logic [15:0]                              hact,
  input  logic [31:0]                              cur_pos,
  input  logic                                     cur_en,
`ifdef CURSOR_SCALE2_EN
  input  logic                                     cur_scale2,
`endif
  input  logic [PIX_W-1:0]                         cur_col0,
  input  logic [PIX_W-1:0]                         cur_col1,
  input  logic [$clog2(CUR_SIZE*CUR_SIZE/16)-1:0]  bm_addr,
  input  logic [31:0]                              bm_wdata,
  input  logic                                     bm_we,
  input  logic [3:0]                               bm_wstrb
);
  localparam int unsigned DW = PIX_PER_BEAT * PIX_W;
  localparam int unsigned AW = $clog2(CUR_SIZE * CUR_SIZE / 16);
  localparam int unsigned NW = CUR_SIZE * CUR_SIZE / 16;

  logic [31:0]             r_bm [NW];
  logic [15:0]             r_x, r_y;
  logic [31:0]             r_pos;
  logic                    r_en, r_scale;
  logic [PIX_W-1:0]        r_col0, r_col1;
  logic                    r_s1_valid;
  logic [DW-1:0]           r_s1_data;
  logic [2*PIX_PER_BEAT-1:0] r_s1_code;
  logic [PIX_W-1:0]        r_s1_col0, r_s1_col1;

  logic [15:0]             w_bx, w_by;
  logic [31:0]             w_pos;
  logic                    w_en, w_scale, w_scale_in;
  logic [PIX_W-1:0]        w_col0, w_col1;
  logic [2*PIX_PER_BEAT-1:0] w_code;
  logic [DW-1:0]           w_comp;
  logic [15:0]             w_xn;

`ifdef CURSOR_SCALE2_EN
  assign w_scale_in = cur_scale2;
`else
  assign w_scale_in = 1'b0;
`endif

  // A beat arriving with frame_start is pixel (0,0) and sees the freshly latched values.
  assign w_bx    = frame_start ? '0 : r_x;
  assign w_by    = frame_start ? '0 : r_y;
  assign w_pos   = frame_start ? cur_pos    : r_pos;
  assign w_en    = frame_start ? cur_en     : r_en;
  assign w_col0  = frame_start ? cur_col0   : r_col0;
  assign w_col1  = frame_start ? cur_col1   : r_col1;
  assign w_scale = frame_start ? w_scale_in : r_scale;
  assign w_xn    = w_bx + 16'(PIX_PER_BEAT);

  always_comb begin
    logic [16:0]   rx, ry;
    logic [15:0]   cx, cy, lim;
    logic [31:0]   wd;
    logic [AW-1:0] wa;
    logic [4:0]    sh;
    w_code = '0;
    lim = w_scale ? 16'(2 * CUR_SIZE) : 16'(CUR_SIZE);
    ry  = {1'b0, w_by} - {w_pos[15], w_pos[15:0]};
    cy  = w_scale ? {1'b0, ry[15:1]} : ry[15:0];
    for (int unsigned i = 0; i < PIX_PER_BEAT; i++) begin
      rx = {1'b0, w_bx} + 17'(i) - {w_pos[31], w_pos[31:16]};
      cx = w_scale ? {1'b0, rx[15:1]} : rx[15:0];
      wa = AW'(32'(cy) * (CUR_SIZE / 16) + 32'(cx[15:4]));
      wd = r_bm[wa];
      sh = {cx[3:0], 1'b0};
      if (w_en && !rx[16] && !ry[16] && (rx[15:0] < lim) && (ry[15:0] < lim))
        w_code[2*i +: 2] = 2'(wd >> (5'd30 - sh));
    end
  end

  always_comb begin
    w_comp = '0;
    for (int unsigned i = 0; i < PIX_PER_BEAT; i++) begin
      case (r_s1_code[2*i +: 2])
        2'b00:   w_comp[PIX_W*i +: PIX_W] = r_s1_data[PIX_W*i +: PIX_W];
        2'b01:   w_comp[PIX_W*i +: PIX_W] = r_s1_col0;
        2'b10:   w_comp[PIX_W*i +: PIX_W] = r_s1_col1;
        default: w_comp[PIX_W*i +: PIX_W] = ~r_s1_data[PIX_W*i +: PIX_W];
      endcase
    end
  end

  // Bitmap storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (bm_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (bm_wstrb[b]) r_bm[bm_addr][8*b +: 8] <= bm_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x        <= '0;
      r_y        <= '0;
      r_pos      <= '0;
      r_en       <= 1'b0;
      r_scale    <= 1'b0;
      r_col0     <= '0;
      r_col1     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_code  <= '0;
      r_s1_col0  <= '0;
      r_s1_col1  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (frame_start) begin
        r_pos   <= cur_pos;
        r_en    <= cur_en;
        r_scale <= w_scale_in;
        r_col0  <= cur_col0;
        r_col1  <= cur_col1;
      end
      if (in_valid) begin
        if (w_xn == hact) begin
          r_x <= '0;
          r_y <= w_by + 16'd1;
        end else begin
          r_x <= w_xn;
          r_y <= w_by;
        end
      end else if (frame_start) begin
        r_x <= '0;
        r_y <= '0;
      end
      // Colours travel with the beat so a later frame_start cannot recolour in-flight pixels.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_code <= w_code;
        r_s1_col0 <= w_col0;
        r_s1_col1 <= w_col1;
      end
      out_valid <= r_s1_valid;
      if (r_s1_valid) out_data <= w_comp;
    end
  end
endmodule
